fifo_wr_arbiter: RTL and testbench

//  Round-robin, packet-locking arbiter that shares the write port of the async FIFO among NUM_REQ

---
 rtl/fifo_arb_pkg.sv | 27 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 130 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared encodings and field layout for the async-FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // fifo_din layout: {last, id, data}, data at the bottom.
   function automatic int unsigned data_lsb();
      return 0;
   endfunction

   function automatic int unsigned id_lsb(input int unsigned dw);
      return dw;
   endfunction

   function automatic int unsigned last_bit(input int unsigned dw, input int unsigned idw);
      return dw + idw;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index starting at rr_ptr.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               any_valid,
   output logic [ID_W-1:0]    pick_id
);

   int unsigned idx;

   // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first hit wins.
   always_comb begin
      any_valid = 1'b0;
      pick_id   = '0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(rr_ptr) + k) % NUM_REQ;
         if (!any_valid && req_valid[ID_W'(idx)]) begin
            any_valid = 1'b1;
            pick_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one async-FIFO write port.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 8,
   localparam int unsigned ID_W      = clog2_min1(NUM_REQ)
) (
   input  logic                          wr_clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH+ID_W:0]      fifo_din,
   output logic [ID_W-1:0]               grant_id,
   output logic                          busy,
   output logic                          burst_err
);

   localparam int unsigned CNT_W    = clog2_min1(MAX_BURST + 1);
   localparam int unsigned LAST_BIT = last_bit(DATA_WIDTH, ID_W);
   localparam int unsigned ID_LSB   = id_lsb(DATA_WIDTH);
   localparam int unsigned DATA_LSB = data_lsb();

   arb_state_e             state_q;
   logic [ID_W-1:0]        grant_q;
   logic [ID_W-1:0]        rr_ptr_q;
   logic [ID_W-1:0]        rr_ptr_d;
   logic [CNT_W-1:0]       beat_cnt_q;
   logic [CNT_W-1:0]       beat_cnt_d;
   logic                   burst_err_q;

   logic                   any_valid;
   logic [ID_W-1:0]        pick_id;
   logic                   g_valid;
   logic                   g_last;
   logic [DATA_WIDTH-1:0]  g_data;
   logic                   in_grant;
   logic                   accept;
   logic                   hit_max;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .any_valid (any_valid),
      .pick_id   (pick_id)
   );

   // Select the granted requester's beat.
   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_q == ID_W'(i)) begin
            g_valid = req_valid[i];
            g_last  = req_last[i];
            g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Handshake, release conditions and FIFO write port; zero-latency path.
   always_comb begin
      in_grant   = (state_q == GRANT);
      accept     = in_grant && g_valid && !fifo_full;
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
      hit_max    = (beat_cnt_d == CNT_W'(MAX_BURST));
      rr_ptr_d   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

      req_ready  = '0;
      if (in_grant && !fifo_full) begin
         req_ready = NUM_REQ'(1) << grant_q;
      end

      fifo_wr_en = accept;
      fifo_din   = '0;
      if (accept) begin
         fifo_din[LAST_BIT]                  = g_last;
         fifo_din[ID_LSB +: ID_W]            = grant_q;
         fifo_din[DATA_LSB +: DATA_WIDTH]    = g_data;
      end

      busy      = in_grant;
      grant_id  = grant_q;
      burst_err = burst_err_q;
   end

   // Arbitration FSM: pick in IDLE, hold the port in GRANT until last or burst limit.
   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         beat_cnt_q  <= '0;
         burst_err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_valid) begin
                  grant_q    <= pick_id;
                  beat_cnt_q <= '0;
                  state_q    <= GRANT;
               end
            end
            GRANT: begin
               if (accept) begin
                  beat_cnt_q <= beat_cnt_d;
                  if (g_last || hit_max) begin
                     state_q  <= IDLE;
                     rr_ptr_q <= rr_ptr_d;
                  end
                  if (hit_max && !g_last) begin
                     burst_err_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=8).
module tb_fifo_wr_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned DW      = 8;
   localparam int unsigned ID_W    = 2;
   localparam int unsigned DIN_W   = DW + ID_W + 1;

   logic                   wr_clk;
   logic                   rst;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_last;
   logic [NUM_REQ*DW-1:0]  req_data;
   logic [NUM_REQ-1:0]     req_ready;
   logic                   fifo_full;
   logic                   fifo_wr_en;
   logic [DIN_W-1:0]       fifo_din;
   logic [ID_W-1:0]        grant_id;
   logic                   busy;
   logic                   burst_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DIN_W-1:0] fifo_q[$];

   fifo_wr_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DW),
      .MAX_BURST  (8)
   ) dut (
      .wr_clk     (wr_clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_last   (req_last),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .grant_id   (grant_id),
      .busy       (busy),
      .burst_err  (burst_err)
   );

   initial begin
      wr_clk = 1'b0;
      forever #5 wr_clk = ~wr_clk;
   end

   // Model of the FIFO: record every written word.
   always @(posedge wr_clk) begin
      if (!rst && fifo_wr_en) fifo_q.push_back(fifo_din);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_data(input int i, input logic [7:0] d);
      req_data[i*DW +: DW] = d;
   endtask

   function automatic logic [31:0] word(input logic last, input int id, input logic [7:0] d);
      return 32'({last, 2'(id), d});
   endfunction

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      fifo_q.delete();
   endtask

   initial begin
      do_reset();
      rst = 1'b1;
      settle();
      check("rst_busy",  32'(busy), 0);
      check("rst_wren",  32'(fifo_wr_en), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_din",   32'(fifo_din), 0);
      check("rst_gid",   32'(grant_id), 0);
      check("rst_berr",  32'(burst_err), 0);
      rst = 1'b0;
      tick();

      // 1: req0 three-beat packet.
      req_valid[0] = 1'b1;
      set_data(0, 8'h11);
      settle();
      check("t1_idle_wren", 32'(fifo_wr_en), 0);
      check("t1_idle_busy", 32'(busy), 0);
      tick();
      check("t1_b1_wren",  32'(fifo_wr_en), 1);
      check("t1_b1_ready", 32'(req_ready), 32'h1);
      check("t1_b1_din",   32'(fifo_din), 32'h011);
      tick();
      set_data(0, 8'h22);
      settle();
      check("t1_b2_din", 32'(fifo_din), 32'h022);
      tick();
      set_data(0, 8'h33);
      req_last[0] = 1'b1;
      settle();
      check("t1_b3_din",  32'(fifo_din), 32'h433);
      check("t1_b3_busy", 32'(busy), 1);
      tick();
      req_valid = '0;
      req_last  = '0;
      settle();
      check("t1_rel_busy", 32'(busy), 0);
      check("t1_rel_wren", 32'(fifo_wr_en), 0);
      check("t1_count",    32'(fifo_q.size()), 3);

      // 2: all requesters valid with single-beat packets.
      do_reset();
      req_valid = 4'hF;
      req_last  = 4'hF;
      for (int i = 0; i < 4; i++) set_data(i, 8'(8'hA0 + i));
      for (int k = 0; k < 12; k++) begin
         settle();
         check($sformatf("t2_wren_%0d", k), 32'(fifo_wr_en), 32'(k % 2));
         if (k % 2 == 1) begin
            check($sformatf("t2_din_%0d", k), 32'(fifo_din),
                  word(1'b1, (k / 2) % 4, 8'(8'hA0 + (k / 2) % 4)));
         end
         tick();
      end
      req_valid = '0;
      req_last  = '0;

      // 3: FIFO full for 5 cycles on beat 2 of req1's 4-beat packet.
      do_reset();
      req_valid[1] = 1'b1;
      set_data(1, 8'h51);
      settle();
      tick();
      check("t3_b1_din", 32'(fifo_din), 32'h151);
      tick();
      set_data(1, 8'h52);
      fifo_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         settle();
         check($sformatf("t3_full_wren_%0d", k), 32'(fifo_wr_en), 0);
         check($sformatf("t3_full_rdy_%0d", k), 32'(req_ready), 0);
         check($sformatf("t3_full_busy_%0d", k), 32'(busy), 1);
         tick();
      end
      fifo_full = 1'b0;
      settle();
      check("t3_b2_din", 32'(fifo_din), 32'h152);
      tick();
      set_data(1, 8'h53);
      settle();
      tick();
      set_data(1, 8'h54);
      req_last[1] = 1'b1;
      settle();
      check("t3_b4_din", 32'(fifo_din), 32'h554);
      tick();
      req_valid = '0;
      req_last  = '0;
      settle();
      check("t3_count", 32'(fifo_q.size()), 4);
      if (fifo_q.size() == 4) begin
         check("t3_w0", 32'(fifo_q[0]), 32'h151);
         check("t3_w1", 32'(fifo_q[1]), 32'h152);
         check("t3_w2", 32'(fifo_q[2]), 32'h153);
         check("t3_w3", 32'(fifo_q[3]), 32'h554);
      end

      // 4: req2 never sets last; forced release after 8 beats, then req3.
      do_reset();
      req_valid = 4'b1100;
      req_last  = 4'b1000;
      set_data(3, 8'h77);
      settle();
      tick();
      check("t4_gid", 32'(grant_id), 2);
      for (int n = 0; n < 8; n++) begin
         set_data(2, 8'(8'h60 + n));
         settle();
         check($sformatf("t4_din_%0d", n), 32'(fifo_din), word(1'b0, 2, 8'(8'h60 + n)));
         check($sformatf("t4_berr_%0d", n), 32'(burst_err), 0);
         tick();
      end
      settle();
      check("t4_rel_busy", 32'(busy), 0);
      check("t4_berr_set", 32'(burst_err), 1);
      tick();
      check("t4_next_gid", 32'(grant_id), 3);
      check("t4_next_din", 32'(fifo_din), 32'h777);
      tick();
      req_valid = '0;
      req_last  = '0;
      tick();
      tick();
      check("t4_berr_sticky", 32'(burst_err), 1);

      // 5: reset in the middle of req1's packet.
      do_reset();
      settle();
      check("t5_berr_clr", 32'(burst_err), 0);
      req_valid[1] = 1'b1;
      req_last[1]  = 1'b1;
      set_data(1, 8'hF1);
      settle();
      tick();
      check("t5_single_din", 32'(fifo_din), 32'h5F1);
      tick();
      req_last[1] = 1'b0;
      set_data(1, 8'h81);
      settle();
      tick();
      check("t5_b1_din", 32'(fifo_din), 32'h181);
      tick();
      set_data(1, 8'h82);
      settle();
      check("t5_b2_wren", 32'(fifo_wr_en), 1);
      rst = 1'b1;
      #1;
      check("t5_rst_busy",  32'(busy), 0);
      check("t5_rst_wren",  32'(fifo_wr_en), 0);
      check("t5_rst_ready", 32'(req_ready), 0);
      check("t5_rst_din",   32'(fifo_din), 0);
      req_valid = 4'b1001;
      req_last  = 4'b1001;
      set_data(0, 8'h90);
      set_data(3, 8'h3D);
      #2;
      rst = 1'b0;
      settle();
      check("t5_post_busy", 32'(busy), 0);
      tick();
      check("t5_post_gid", 32'(grant_id), 0);
      check("t5_post_din", 32'(fifo_din), 32'h490);
      tick();
      req_valid = '0;
      req_last  = '0;

      // 6: req3 stalls mid-packet while req0 waits.
      do_reset();
      req_valid[3] = 1'b1;
      set_data(3, 8'hC1);
      settle();
      tick();
      req_valid[0] = 1'b1;
      req_last[0]  = 1'b1;
      set_data(0, 8'h0A);
      settle();
      check("t6_b1_din", 32'(fifo_din), 32'h3C1);
      tick();
      req_valid[3] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check($sformatf("t6_gap_wren_%0d", k), 32'(fifo_wr_en), 0);
         check($sformatf("t6_gap_rdy_%0d", k), 32'(req_ready), 32'h8);
         check($sformatf("t6_gap_gid_%0d", k), 32'(grant_id), 3);
         tick();
      end
      req_valid[3] = 1'b1;
      set_data(3, 8'hC2);
      settle();
      check("t6_b2_din", 32'(fifo_din), 32'h3C2);
      tick();
      set_data(3, 8'hC3);
      req_last[3] = 1'b1;
      settle();
      check("t6_b3_din", 32'(fifo_din), 32'h7C3);
      tick();
      req_valid[3] = 1'b0;
      settle();
      check("t6_idle_wren", 32'(fifo_wr_en), 0);
      tick();
      check("t6_r0_gid", 32'(grant_id), 0);
      check("t6_r0_din", 32'(fifo_din), 32'h40A);
      tick();
      req_valid = '0;
      req_last  = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
